// File: rtl/mojo_com_pkg.sv
// ---------------------------------------------------------------
// mojo_com_pkg: wire-format constants and FSM encodings for mojo_com.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package mojo_com_pkg;

  localparam int WORD_SIZE     = 8;
  localparam int HDR_WRITE_BIT = 7;
  localparam int HDR_LEN_MSB   = 6;
  localparam int MAX_PROTO_LEN = 127;

  typedef logic [WORD_SIZE-1:0]   word_t;
  typedef logic [HDR_LEN_MSB:0]   len_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_WDATA = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Header byte: direction flag in the top bit, byte count below it.
  function automatic word_t make_hdr(input logic write, input len_t len);
    word_t w_hdr;
    w_hdr                = '0;
    w_hdr[HDR_WRITE_BIT] = write;
    w_hdr[HDR_LEN_MSB:0] = len;
    return w_hdr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mojo_com_initiator.sv
// ---------------------------------------------------------------
// mojo_com_initiator: turns one register-window command into the
// mojo_com byte stream and collects read-response bytes.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mojo_com_initiator
  import mojo_com_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [WORD_SIZE-1:0]   cmd_addr,
  input  logic [HDR_LEN_MSB:0]   cmd_len,
  input  logic [8*MAX_LEN-1:0]   wr_data,
  output logic [8*MAX_LEN-1:0]   rd_data,
  output logic [HDR_LEN_MSB:0]   rd_count,
  output logic                   done,
  output logic                   err,
  output logic                   busy,
  output logic [WORD_SIZE-1:0]   ser_tx_data,
  output logic                   ser_new_tx_data,
  input  logic                   ser_tx_busy,
  input  logic [WORD_SIZE-1:0]   ser_rx_data,
  input  logic                   ser_new_rx_data
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]          TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [HDR_LEN_MSB:0]   LEN_LIMIT = (HDR_LEN_MSB + 1)'(MAX_LEN);

  logic [2:0]             r_state;
  logic                   r_write;
  word_t                  r_addr;
  logic [CW-1:0]          r_len;
  logic [8*MAX_LEN-1:0]   r_wr_data;
  logic [CW-1:0]          r_idx;
  logic                   r_gap;
  logic [TW-1:0]          r_tmo;
  logic [8*MAX_LEN-1:0]   r_rd_data;
  logic [CW-1:0]          r_rd_count;
  logic                   r_err;
  logic                   r_done;
  logic                   r_busy;
  logic                   r_cmd_ready;
  word_t                  r_tx_data;
  logic                   r_tx_strobe;

  logic [2:0]             w_state_nxt;
  logic                   w_send;
  word_t                  w_send_byte;
  logic                   w_err_nxt;
  logic                   w_accept;
  logic                   w_len_bad;
  logic                   w_tx_ok;
  logic                   w_last_wr;
  logic                   w_rx_take;
  logic                   w_rx_last;
  logic                   w_tmo_hit;
  logic [CW-1:0]          w_rd_next;
  word_t                  w_hdr;
  word_t                  w_wr_byte;

  assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
  assign w_len_bad = (cmd_len == '0) || (cmd_len > LEN_LIMIT);
  // The cycle after a strobe is a forced gap: the UART has not yet raised busy.
  assign w_tx_ok   = !r_gap && !ser_tx_busy;
  assign w_last_wr = (r_idx == (r_len - CW'(1)));
  assign w_rx_take = (r_state == ST_RDATA) && ser_new_rx_data;
  assign w_rd_next = r_rd_count + CW'(1);
  assign w_rx_last = (w_rd_next == r_len);
  assign w_tmo_hit = (r_tmo == TMO_LIMIT);
  assign w_hdr     = make_hdr(r_write, (HDR_LEN_MSB + 1)'(r_len));
  assign w_wr_byte = r_wr_data[WORD_SIZE*int'(r_idx) +: WORD_SIZE];

  always_comb begin
    w_state_nxt = r_state;
    w_send      = 1'b0;
    w_send_byte = r_addr;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = w_len_bad ? ST_DONE : ST_HDR;
          w_err_nxt   = w_len_bad;
        end
      end
      ST_HDR: begin
        if (w_tx_ok) begin
          w_send      = 1'b1;
          w_send_byte = w_hdr;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_tx_ok) begin
          w_send      = 1'b1;
          w_send_byte = r_addr;
          w_state_nxt = r_write ? ST_WDATA : ST_RDATA;
        end
      end
      ST_WDATA: begin
        if (w_tx_ok) begin
          w_send      = 1'b1;
          w_send_byte = w_wr_byte;
          if (w_last_wr) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_RDATA: begin
        // A byte arriving on the timeout cycle takes priority over the abort.
        if (ser_new_rx_data) begin
          if (w_rx_last) begin
            w_state_nxt = ST_DONE;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_wr_data   <= '0;
      r_idx       <= '0;
      r_gap       <= 1'b0;
      r_tmo       <= '0;
      r_rd_data   <= '0;
      r_rd_count  <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_tx_data   <= '0;
      r_tx_strobe <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_err       <= w_err_nxt;
      r_tx_strobe <= w_send;
      r_gap       <= w_send;
      if (w_send) begin
        r_tx_data <= w_send_byte;
      end

      if (w_accept) begin
        r_write    <= cmd_write;
        r_addr     <= cmd_addr;
        r_len      <= CW'(cmd_len);
        r_wr_data  <= wr_data;
        r_idx      <= '0;
        r_rd_data  <= '0;
        r_rd_count <= '0;
      end

      if ((r_state == ST_WDATA) && w_send) begin
        r_idx <= r_idx + CW'(1);
      end

      if ((r_state == ST_ADDR) && w_send) begin
        r_tmo <= '0;
      end else if (w_rx_take) begin
        r_rd_data[WORD_SIZE*int'(r_rd_count) +: WORD_SIZE] <= ser_rx_data;
        r_rd_count <= w_rd_next;
        r_tmo      <= '0;
      end else if ((r_state == ST_RDATA) && !w_tmo_hit) begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign rd_data         = r_rd_data;
  assign rd_count        = (HDR_LEN_MSB + 1)'(r_rd_count);
  assign ser_tx_data     = r_tx_data;
  assign ser_new_tx_data = r_tx_strobe;

endmodule

`default_nettype wire

// File: tb/tb_mojo_com_initiator.sv
// ---------------------------------------------------------------
// tb_mojo_com_initiator: directed bench with UART/responder model.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mojo_com_initiator;

  localparam int ML  = 16;
  localparam int TMO = 300;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [7:0]      cmd_addr;
  logic [6:0]      cmd_len;
  logic [8*ML-1:0] wr_data;
  logic [8*ML-1:0] rd_data;
  logic [6:0]      rd_count;
  logic            done;
  logic            err;
  logic            busy;
  logic [7:0]      ser_tx_data;
  logic            ser_new_tx_data;
  logic            ser_tx_busy;
  logic [7:0]      ser_rx_data;
  logic            ser_new_rx_data;

  mojo_com_initiator #(.MAX_LEN(ML), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .rd_data(rd_data), .rd_count(rd_count), .done(done), .err(err), .busy(busy),
    .ser_tx_data(ser_tx_data), .ser_new_tx_data(ser_new_tx_data),
    .ser_tx_busy(ser_tx_busy), .ser_rx_data(ser_rx_data),
    .ser_new_rx_data(ser_new_rx_data)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: what the current command must put on the wire and return.
  logic [7:0]      tx_exp[$];
  logic            exp_err;
  int              exp_count;
  logic [8*ML-1:0] exp_rd;
  bit              model_busy = 0;
  int              done_seen  = 0;
  int              done_cyc   = 0;
  logic            done_err_l;
  logic [6:0]      done_cnt_l;

  // UART / responder model state.
  logic [7:0] tx_log[$];
  logic [7:0] rep_bytes[$];
  int         resp_n      = 0;
  logic [7:0] resp_hdr    = 8'h00;
  bit         reply_go    = 0;
  int         rgap        = 0;
  int         busy_cnt    = 0;
  bit         hold_busy   = 0;
  bit         stray       = 0;
  int         last_rx_cyc = 0;
  logic       busy_at_edge = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= ser_tx_busy;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic log_check(input string nm, input logic [63:0] bytes, input int n);
    check({nm, "_n"}, 128'(tx_log.size()), 128'(n));
    for (int i = 0; i < n; i++) begin
      check(nm, (i < tx_log.size()) ? 128'(tx_log[i]) : 128'hx,
            128'(bytes[8*(n-1-i) +: 8]));
    end
  endtask

  // UART tx (busy 10 clks per byte) plus responder that answers reads.
  initial begin
    ser_tx_busy     = 1'b0;
    ser_rx_data     = 8'h00;
    ser_new_rx_data = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ser_new_tx_data) begin
        tx_log.push_back(ser_tx_data);
        busy_cnt = 10;
        resp_n++;
        if (resp_n == 1) resp_hdr = ser_tx_data;
        if (resp_n == 2 && (!resp_hdr[7] || stray)) begin
          reply_go = 1;
          rgap     = 3;
        end
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      ser_tx_busy     = (busy_cnt > 0) || hold_busy;
      ser_new_rx_data = 1'b0;
      if (reply_go && rep_bytes.size() > 0) begin
        if (rgap > 0) rgap--;
        else begin
          ser_rx_data     = rep_bytes.pop_front();
          ser_new_rx_data = 1'b1;
          last_rx_cyc     = cyc;
          rgap            = 3;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    bit prev_strobe;
    prev_strobe = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (ser_new_tx_data) begin
          if (tx_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_extra: got byte %h expected no strobe", ser_tx_data);
          end else begin
            check("tx_byte", 128'(ser_tx_data), 128'(tx_exp.pop_front()));
          end
          check("tx_while_busy", 128'(busy_at_edge), 128'(0));
          check("tx_rate", 128'(prev_strobe), 128'(0));
        end
        prev_strobe = ser_new_tx_data;
        check("cmd_ready", 128'(cmd_ready), 128'(!model_busy));
        if (done) begin
          check("done_expected", 128'(model_busy), 128'(1));
          check("err", 128'(err), 128'(exp_err));
          check("rd_count", 128'(rd_count), 128'(exp_count));
          check("rd_data", rd_data, exp_rd);
          check("tx_left", 128'(tx_exp.size()), 128'(0));
          check("busy_in_done", 128'(busy), 128'(0));
          done_err_l = err;
          done_cnt_l = rd_count;
          done_seen++;
          done_cyc   = cyc;
          model_busy = 0;
        end else begin
          check("busy", 128'(busy), 128'(model_busy));
          check("err_idle", 128'(err), 128'(0));
        end
      end else begin
        prev_strobe = 0;
      end
    end
  end

  task automatic issue(input bit w, input logic [7:0] a, input int len, input logic [8*ML-1:0] wd);
    int t;
    int n;
    bit legal;
    t = 0;
    @(negedge clk); #1;
    while (!cmd_ready && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    check("ready_wait", 128'(cmd_ready), 128'(1));
    legal = (len >= 1) && (len <= ML);
    tx_exp.delete();
    tx_log.delete();
    exp_rd    = '0;
    exp_count = 0;
    exp_err   = !legal;
    if (legal) begin
      tx_exp.push_back({w, 7'(len)});
      tx_exp.push_back(a);
      if (w) begin
        for (int i = 0; i < len; i++) tx_exp.push_back(wd[8*i +: 8]);
      end else begin
        n = (rep_bytes.size() < len) ? rep_bytes.size() : len;
        for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = rep_bytes[i];
        exp_count = n;
        exp_err   = (n < len);
      end
    end
    resp_n    = 0;
    reply_go  = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = 7'(len);
    wr_data   = wd;
    @(negedge clk); #1;
    cmd_valid  = 1'b0;
    wr_data    = '0;
    model_busy = 1;
  endtask

  task automatic wait_done(input string nm, input int start, input int budget);
    int t;
    t = 0;
    while (done_seen == start && t < budget) begin
      @(negedge clk); #3;
      t++;
    end
    check({nm, "_done"}, 128'(done_seen != start), 128'(1));
  endtask

  initial begin
    int d0;
    int rst_d;
    bit found;
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int dt;
    bit found;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_len   = 7'd0;
    wr_data   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_strobe", 128'(ser_new_tx_data), 128'(0));
    check("rst_rd_data", rd_data, 128'(0));
    check("rst_rd_count", 128'(rd_count), 128'(0));
    rst_n = 1'b1;

    // Write with a stray rx byte that must be ignored.
    stray = 1;
    rep_bytes.delete(); rep_bytes.push_back(8'h5A);
    d0 = done_seen;
    issue(1'b1, 8'h10, 3, 128'h332211);
    wait_done("wr1", d0, 200);
    log_check("wr1_tx", 64'h8310112233, 5);
    check("wr1_err", 128'(done_err_l), 128'(0));
    check("wr1_cnt", 128'(done_cnt_l), 128'(0));
    stray = 0;

    // Read, two bytes answered.
    rep_bytes.delete(); rep_bytes.push_back(8'hAA); rep_bytes.push_back(8'hBB);
    d0 = done_seen;
    issue(1'b0, 8'h05, 2, '0);
    wait_done("rd1", d0, 200);
    log_check("rd1_tx", 64'h0205, 2);
    check("rd1_data", 128'(rd_data[15:0]), 128'(16'hBBAA));
    check("rd1_cnt", 128'(rd_count), 128'(2));
    check("rd1_err", 128'(done_err_l), 128'(0));

    // Read len 4 with only two replies: timeout keeps partial data.
    rep_bytes.delete(); rep_bytes.push_back(8'hC1); rep_bytes.push_back(8'hC2);
    d0 = done_seen;
    issue(1'b0, 8'h20, 4, '0);
    wait_done("tmo", d0, TMO + 300);
    check("tmo_err", 128'(done_err_l), 128'(1));
    check("tmo_cnt", 128'(done_cnt_l), 128'(2));
    check("tmo_data", rd_data, 128'(16'hC2C1));
    dt = done_cyc - last_rx_cyc;
    check("tmo_window", 128'((dt >= TMO) && (dt <= TMO + 3)), 128'(1));

    // Illegal lengths.
    rep_bytes.delete();
    d0 = done_seen;
    issue(1'b1, 8'h00, 0, 128'hFF);
    wait_done("len0", d0, 2);
    check("len0_err", 128'(done_err_l), 128'(1));
    check("len0_tx", 128'(tx_log.size()), 128'(0));
    d0 = done_seen;
    issue(1'b0, 8'h00, ML + 1, '0);
    wait_done("len17", d0, 2);
    check("len17_err", 128'(done_err_l), 128'(1));
    check("len17_tx", 128'(tx_log.size()), 128'(0));

    // UART busy held during header.
    hold_busy = 1;
    d0 = done_seen;
    issue(1'b1, 8'h40, 1, 128'h77);
    repeat (100) @(negedge clk);
    #1;
    check("hold_no_tx", 128'(tx_log.size()), 128'(0));
    hold_busy = 0;
    wait_done("hold", d0, 200);
    log_check("hold_tx", 64'h814077, 3);

    // Reset while first data byte is being strobed.
    d0 = done_seen;
    issue(1'b1, 8'h30, 4, 128'h04030201);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (ser_new_tx_data && ser_tx_data == 8'h01) found = 1;
    end
    check("rst_mid_found", 128'(found), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobe", 128'(ser_new_tx_data), 128'(0));
    check("rst_mid_busy", 128'(busy), 128'(0));
    check("rst_mid_ready", 128'(cmd_ready), 128'(1));
    check("rst_mid_done", 128'(done), 128'(0));
    tx_exp.delete();
    model_busy = 0;
    busy_cnt   = 0;
    resp_n     = 0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    check("rst_mid_no_done", 128'(done_seen), 128'(d0));

    // Address near the top of the window goes out unmodified.
    d0 = done_seen;
    issue(1'b1, 8'hFF, 2, 128'hCDAB);
    wait_done("wr2", d0, 200);
    log_check("wr2_tx", 64'h82FFABCD, 4);
    check("wr2_err", 128'(done_err_l), 128'(0));

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
